// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Brief    : State encoding and coin constants shared by the vending path.
// Revision : 1.0
// ============================================================================
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam int UNIT_RUPEES  = 5;
    localparam int COIN10_UNITS = 2;
    localparam int COIN5_UNITS  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0
// ============================================================================
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Brief    : Greedy coin-return transmitter (10s then 5s) with ack handshake.
// Revision : 1.0
// ============================================================================
module change_dispenser
    import vending_pkg::*;
#(
    parameter int UNIT_W      = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [UNIT_W-1:0] units,
    input  logic              empty10,
    input  logic              empty5,
    input  logic              coin_ack,
    input  logic              clear,
    output logic              coin10,
    output logic              coin5,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [UNIT_W-1:0] remaining
);

    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMR_W = max_int(TO_W, GAP_W);

    state_e            state_q,  state_d;
    logic [UNIT_W-1:0] rem_q,    rem_d;
    logic              coin10_q, coin10_d;
    logic              coin5_q,  coin5_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              fault_q,  fault_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_dec;
    logic [TMR_W-1:0]  tmr_count;
    logic              tmr_zero;

    // One timer serves both the EJECT timeout and the GAP length; it is
    // loaded with N-1 so the state lasts exactly N cycles.
    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        coin10_d = coin10_q;
        coin5_d  = coin5_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SELECT;
                    rem_d   = units;
                    busy_d  = 1'b1;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if ((rem_q >= UNIT_W'(COIN10_UNITS)) && !empty10) begin
                    state_d  = ST_EJECT;
                    coin10_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ACK_TIMEOUT - 1);
                end else if ((rem_q >= UNIT_W'(COIN5_UNITS)) && !empty5) begin
                    state_d  = ST_EJECT;
                    coin5_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ACK_TIMEOUT - 1);
                end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_EJECT: begin
                if (coin_ack) begin
                    rem_d    = rem_q - (coin10_q ? UNIT_W'(COIN10_UNITS)
                                                 : UNIT_W'(COIN5_UNITS));
                    coin10_d = 1'b0;
                    coin5_d  = 1'b0;
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYCLES - 1);
                end else if (tmr_zero) begin
                    coin10_d = 1'b0;
                    coin5_d  = 1'b0;
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_SELECT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rem_d    = '0;
                coin10_d = 1'b0;
                coin5_d  = 1'b0;
                busy_d   = 1'b0;
                fault_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            coin10_q <= 1'b0;
            coin5_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            coin10_q <= coin10_d;
            coin5_q  <= coin5_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign coin10    = coin10_q;
    assign coin5     = coin5_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = rem_q;

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Coin-return transmitter for the vending path. The vending FSM consumes `coin5`/`coin10` pulses from the coin acceptor. This block drives the same two coin lines in the opposite direction, toward the change hopper. Given a refund amount in 5-rupee units, it ejects coins greedily (10s first, then 5s), one at a time, using a hold-until-ack handshake with the hopper, a programmable inter-coin gap, and fault reporting.

## Interface
Parameters:
- `UNIT_W`, default 8: width of the refund amount in 5-rupee units.
- `GAP_CYCLES`, default 2: idle cycles between coins; legal range ≥1.
- `ACK_TIMEOUT`, default 16: maximum EJECT cycles without ack before FAULT; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  pulse; request a refund of `units`. Honoured in IDLE only.
- `units`  in  UNIT_W  refund amount (1 unit = 5 rupees); sampled with `start`.
- `empty10`  in  1  10-rupee hopper empty.
- `empty5`  in  1  5-rupee hopper empty.
- `coin_ack`  in  1  hopper has released the requested coin.
- `clear`  in  1  leave FAULT.
- `coin10`  out  1  eject one 10-rupee coin; registered.
- `coin5`  out  1  eject one 5-rupee coin; registered.
- `busy`  out  1  high in SELECT, EJECT, GAP and DONE.
- `done`  out  1  one-cycle pulse when the refund completes.
- `fault`  out  1  held high in FAULT.
- `remaining`  out  UNIT_W  units not yet ejected.

## Operation
States: IDLE, SELECT, EJECT, GAP, DONE, FAULT.
- IDLE: on `start`, load `rem <= units`, go to SELECT.
- SELECT: evaluate in priority order; the first true condition wins.
  - `rem==0` → DONE.
  - `rem>=2 && !empty10` → set `coin10`, go to EJECT.
  - `rem>=1 && !empty5` → set `coin5`, go to EJECT.
  - Otherwise → FAULT.
  - A 10 coin is never ejected for `rem==1`. When `empty10=1`, 5s are used for all of `rem`.
- EJECT: hold the selected coin line high until `coin_ack` is sampled high.
  - On ack: `rem -= 2` (10) or `rem -= 1` (5), both coin lines low, go to GAP.
  - No ack for `ACK_TIMEOUT` consecutive EJECT cycles → coin lines low, `rem` unchanged, go to FAULT.
  - Ack and timeout in the same cycle: ack wins.
- GAP: stay `GAP_CYCLES` cycles, then go to SELECT.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- FAULT: `fault=1`, `remaining` shows undispensed units. `clear` → IDLE with `rem` zeroed.
- Ignored inputs:
  - `start` in any state other than IDLE.
  - `coin_ack` outside EJECT.
  - `empty5`/`empty10` outside SELECT.
  - `clear` outside FAULT.
- `coin10` and `coin5` are never high together.
- Arithmetic: `rem` is UNIT_W bits and can never underflow because of the SELECT guards. The EJECT timeout counter is sized with `$clog2(ACK_TIMEOUT+1)` and cleared on entering EJECT.

## Timing
- Reset (async, immediate): state IDLE. `coin10=0`, `coin5=0`, `busy=0`, `done=0`, `fault=0`, `remaining=0`, all counters 0.
- Cycle numbering below counts from the edge that samples `start`, called edge 0.
  - Edge 0: state becomes SELECT and `busy=1`.
  - Edge 1: coin line goes high (EJECT).
  - Edge n: first edge at which `coin_ack=1` is sampled; coin line drops and `remaining` updates.
  - Edges n+1 … n+GAP_CYCLES: GAP.
  - Then SELECT again.
- Minimum coin period (ack arriving on the first EJECT cycle): GAP_CYCLES+2 cycles.
- `units=0`: `done` is high in the cycle after edge 1; no coin is ejected.
- `done` is high in the cycle following the SELECT that sees `rem==0`. `busy` stays 1 during DONE and drops with the return to IDLE.
- Reset asserted mid-EJECT: coin lines drop asynchronously and any partial refund is abandoned.

## Structure
- Shared package `vending_pkg` holds:
  - state encoding, shared with the acceptor FSM;
  - `UNIT_RUPEES=5`;
  - `COIN10_UNITS=2`, `COIN5_UNITS=1`.
- One sub-module, `cycle_timer`: a loadable down-counter with a zero flag. It is reused for the GAP count and for the EJECT timeout.
- Everything else stays flat: the state register, `rem`, and registered outputs.

## Test plan
Default parameters throughout.
- **Mixed refund:** `units=3`, hoppers full, ack 2 cycles after each coin rises.
  - Expect one `coin10`, then 2 GAP cycles, then one `coin5`.
  - `remaining` goes 3→1→0, then a single `done` pulse, then `busy=0`.
- **10-hopper empty:** `units=4`, `empty10=1`.
  - Expect four `coin5` pulses, no `coin10`, then `done`.
- **5-hopper empty:** `units=3`, `empty5=1`.
  - Expect one `coin10`, then FAULT with `fault=1`, `remaining=1`, `done` never asserted.
  - `clear` → IDLE with `remaining=0`.
- **Ack timeout:** `units=2`, `coin_ack` held 0.
  - `coin10` stays high for exactly 16 cycles, then drops.
  - `fault=1`, `remaining=2`.
- **Zero refund and ignored inputs:** `units=0`.
  - Expect `done` high in the cycle after edge 1 and no coin pulse.
  - `start` with `units=7` during an active refund is ignored: `remaining` is unaffected.
- **Reset mid-EJECT:** assert `reset` while `coin10=1`.
  - All outputs go 0 without waiting for a clock edge.
  - After release, a new `start` with `units=1` produces one `coin5` and then `done`.
